// File: rtl/pipe_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline sequencing controller.
//   state_t          : controller FSM state (RUN, WAIT)
//   REG_W            : register-index width used by the hazard compare
//   WCNT_W           : width of the internal memory-wait counter
//   CNT_W_DEFAULT    : default width of the statistics counters
//   MAX_WAIT_DEFAULT : default wait count at which mem_timeout sets
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_W            = 4;
    localparam int WCNT_W           = 8;
    localparam int CNT_W_DEFAULT    = 16;
    localparam int MAX_WAIT_DEFAULT = 255;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Bundle of pipeline-status inputs and sequencing outputs exchanged between
// the pipeline datapath (master) and the stall controller (slave).
//   inputs to controller : forward_en, id_src1/2, id_one_src, id_two_src,
//                          exe_dest, exe_wb_en, exe_mem_read, mem_dest,
//                          mem_wb_en, mem_req, mem_ready, branch_taken,
//                          stat_clr
//   outputs from ctrl    : hazard, freeze, flush, mem_timeout,
//                          stall_cnt, wait_cnt
// ----------------------------------------------------------------------------
interface pipe_stall_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             forward_en;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_one_src;
    logic             id_two_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;
    logic             stat_clr;

    logic             hazard;
    logic             freeze;
    logic             flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] wait_cnt;

    // Pipeline datapath side.
    modport master (
        output forward_en, id_src1, id_src2, id_one_src, id_two_src,
        output exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
        output mem_req, mem_ready, branch_taken, stat_clr,
        input  hazard, freeze, flush, mem_timeout, stall_cnt, wait_cnt
    );

    // Stall controller side.
    modport slave (
        input  forward_en, id_src1, id_src2, id_one_src, id_two_src,
        input  exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
        input  mem_req, mem_ready, branch_taken, stat_clr,
        output hazard, freeze, flush, mem_timeout, stall_cnt, wait_cnt
    );

endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational read-after-write detector for the instruction in ID.
// Kept free of interface ports so the forwarding unit can reuse it.
//   forward_en            : forwarding enabled -> only load-use is a hazard
//   id_src1/2, id_*_src   : ID source registers and their use flags
//   exe_dest/wb_en/mem_read : producer in EXE
//   mem_dest/wb_en        : producer in MEM
//   raw                   : ID must wait for a producer
// ----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             forward_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_one_src,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             raw
);

    logic hit_exe;
    logic hit_mem;

    assign hit_exe = exe_wb_en & ((id_one_src & (id_src1 == exe_dest)) |
                                  (id_two_src & (id_src2 == exe_dest)));
    assign hit_mem = mem_wb_en & ((id_one_src & (id_src1 == mem_dest)) |
                                  (id_two_src & (id_src2 == mem_dest)));

    // With forwarding, every producer can be bypassed except a load still in
    // EXE, whose data only exists after the memory stage.
    assign raw = forward_en ? (hit_exe & exe_mem_read) : (hit_exe | hit_mem);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
// Pipeline sequencing controller: decode bubbles (hazard), whole-pipe freeze
// during multi-cycle data-memory accesses, front-end flush on taken branch,
// saturating stall statistics and a sticky memory-timeout flag.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pipe_stall_ctrl_if.slave (pipeline status in, sequencing out)
// Priority among simultaneous events: freeze > flush > hazard.
// ----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    pipe_stall_ctrl_if.slave    bus
);

    logic raw;
    logic freeze_c;
    logic hazard_c;
    logic flush_c;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    hazard_detect u_hazard_detect (
        .forward_en   (bus.forward_en),
        .id_src1      (bus.id_src1),
        .id_src2      (bus.id_src2),
        .id_one_src   (bus.id_one_src),
        .id_two_src   (bus.id_two_src),
        .exe_dest     (bus.exe_dest),
        .exe_wb_en    (bus.exe_wb_en),
        .exe_mem_read (bus.exe_mem_read),
        .mem_dest     (bus.mem_dest),
        .mem_wb_en    (bus.mem_wb_en),
        .raw          (raw)
    );

    // Freeze depends only on the live handshake, not on the FSM state, so a
    // single-cycle access never stalls. The rst term keeps the combinational
    // outputs quiet while the block is held in reset.
    assign freeze_c = rst & bus.mem_req & ~bus.mem_ready;
    // A frozen branch stays in EXE; its flush lands in the release cycle.
    assign flush_c  = rst & bus.branch_taken & ~freeze_c;
    // The ID instruction is discarded by a flush, so no bubble is needed.
    assign hazard_c = rst & raw & ~freeze_c & ~bus.branch_taken;

    assign bus.freeze      = freeze_c;
    assign bus.flush       = flush_c;
    assign bus.hazard      = hazard_c;
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.wait_cnt    = wait_q;

    // NOTE: every signal written here gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        stall_d   = stall_q;
        wait_d    = wait_q;

        case (state_q)
            RUN:     if (bus.mem_req && !bus.mem_ready) state_d = WAIT;
            WAIT:    if (bus.mem_ready || !bus.mem_req) state_d = RUN;
            default: state_d = RUN;
        endcase

        // Counter is zero whenever RUN is (re)entered; it counts only cycles
        // actually spent in WAIT that continue waiting.
        if (state_d == RUN) begin
            wcnt_d = '0;
        end else if (state_q == WAIT) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        if (bus.stat_clr) begin
            timeout_d = 1'b0;
            stall_d   = '0;
            wait_d    = '0;
        end else begin
            if (state_q == WAIT && wcnt_q == WCNT_W'(MAX_WAIT - 1)) begin
                timeout_d = 1'b1;
            end
            if (hazard_c && stall_q != '1) stall_d = stall_q + 1'b1;
            if (freeze_c && wait_q  != '1) wait_d  = wait_q  + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            wait_q    <= wait_d;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed self-checking bench for pipe_stall_ctrl with MAX_WAIT=4, CNT_W=4.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled on the falling edge, registered outputs 1 unit after the edge.
// ----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.forward_en   = 1'b0;
        bus.id_src1      = '0;
        bus.id_src2      = '0;
        bus.id_one_src   = 1'b0;
        bus.id_two_src   = 1'b0;
        bus.exe_dest     = '0;
        bus.exe_wb_en    = 1'b0;
        bus.exe_mem_read = 1'b0;
        bus.mem_dest     = '0;
        bus.mem_wb_en    = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.stat_clr     = 1'b0;
    endtask

    // ID reads r3 as src1 while the EXE instruction writes r3.
    task automatic set_exe_raw(input logic fwd, input logic load);
        bus.forward_en   = fwd;
        bus.exe_wb_en    = 1'b1;
        bus.exe_dest     = 4'd3;
        bus.id_src1      = 4'd3;
        bus.id_one_src   = 1'b1;
        bus.exe_mem_read = load;
    endtask

    task automatic clr_stats();
        idle();
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        set_exe_raw(1'b0, 1'b0);
        bus.mem_req      = 1'b1;
        bus.branch_taken = 1'b1;
        #2;
        total++; if (bus.hazard !== 1'b0) $display("FAIL rst_hazard: got %0b want 0", bus.hazard); else passed++;
        total++; if (bus.freeze !== 1'b0) $display("FAIL rst_freeze: got %0b want 0", bus.freeze); else passed++;
        total++; if (bus.flush !== 1'b0) $display("FAIL rst_flush: got %0b want 0", bus.flush); else passed++;
        total++; if (bus.mem_timeout !== 1'b0) $display("FAIL rst_timeout: got %0b want 0", bus.mem_timeout); else passed++;
        total++; if (bus.stall_cnt !== 4'd0) $display("FAIL rst_stall_cnt: got %0d want 0", bus.stall_cnt); else passed++;
        total++; if (bus.wait_cnt !== 4'd0) $display("FAIL rst_wait_cnt: got %0d want 0", bus.wait_cnt); else passed++;
        idle();
        #8 rst = 1'b1;
        tick();
    endtask

    task automatic test_no_forward_raw();
        clr_stats();
        set_exe_raw(1'b0, 1'b0);
        @(negedge clk);
        total++; if (bus.hazard !== 1'b1) $display("FAIL nf_exe_hazard: got %0b want 1", bus.hazard); else passed++;
        total++; if (bus.flush !== 1'b0) $display("FAIL nf_exe_flush: got %0b want 0", bus.flush); else passed++;
        tick();
        idle();
        total++; if (bus.stall_cnt !== 4'd1) $display("FAIL nf_stall_cnt1: got %0d want 1", bus.stall_cnt); else passed++;
        // MEM-stage producer on src2.
        bus.mem_wb_en  = 1'b1;
        bus.mem_dest   = 4'd7;
        bus.id_src2    = 4'd7;
        bus.id_two_src = 1'b1;
        @(negedge clk);
        total++; if (bus.hazard !== 1'b1) $display("FAIL nf_mem_hazard: got %0b want 1", bus.hazard); else passed++;
        tick();
        bus.forward_en = 1'b1;
        @(negedge clk);
        total++; if (bus.hazard !== 1'b0) $display("FAIL fw_mem_hazard: got %0b want 0", bus.hazard); else passed++;
        tick();
        idle();
        total++; if (bus.stall_cnt !== 4'd2) $display("FAIL nf_stall_cnt2: got %0d want 2", bus.stall_cnt); else passed++;
    endtask

    task automatic test_forward_load_use();
        clr_stats();
        set_exe_raw(1'b1, 1'b0);
        @(negedge clk);
        total++; if (bus.hazard !== 1'b0) $display("FAIL fw_alu_hazard: got %0b want 0", bus.hazard); else passed++;
        tick();
        bus.exe_mem_read = 1'b1;
        @(negedge clk);
        total++; if (bus.hazard !== 1'b1) $display("FAIL fw_load_hazard: got %0b want 1", bus.hazard); else passed++;
        tick();
        bus.id_one_src = 1'b0;
        bus.id_src1    = 4'd5;
        bus.id_src2    = 4'd3;
        bus.id_two_src = 1'b0;
        @(negedge clk);
        total++; if (bus.hazard !== 1'b0) $display("FAIL fw_src2_unused: got %0b want 0", bus.hazard); else passed++;
        tick();
        bus.id_two_src = 1'b1;
        @(negedge clk);
        total++; if (bus.hazard !== 1'b1) $display("FAIL fw_src2_used: got %0b want 1", bus.hazard); else passed++;
        tick();
        idle();
        total++; if (bus.stall_cnt !== 4'd2) $display("FAIL fw_stall_cnt: got %0d want 2", bus.stall_cnt); else passed++;
    endtask

    task automatic test_mem_wait();
        state_t exp_state;
        clr_stats();
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_state = (i == 0) ? RUN : WAIT;
            @(negedge clk);
            total++; if (bus.freeze !== 1'b1) $display("FAIL mw_freeze_c%0d: got %0b want 1", i, bus.freeze); else passed++;
            total++; if (u_dut.state_q !== exp_state) $display("FAIL mw_state_c%0d: got %0d want %0d", i, u_dut.state_q, exp_state); else passed++;
            tick();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.freeze !== 1'b0) $display("FAIL mw_release_freeze: got %0b want 0", bus.freeze); else passed++;
        total++; if (u_dut.state_q !== WAIT) $display("FAIL mw_release_state: got %0d want %0d", u_dut.state_q, WAIT); else passed++;
        tick();
        idle();
        total++; if (u_dut.state_q !== RUN) $display("FAIL mw_back_to_run: got %0d want %0d", u_dut.state_q, RUN); else passed++;
        total++; if (bus.wait_cnt !== 4'd3) $display("FAIL mw_wait_cnt: got %0d want 3", bus.wait_cnt); else passed++;
        total++; if (bus.mem_timeout !== 1'b0) $display("FAIL mw_no_timeout: got %0b want 0", bus.mem_timeout); else passed++;
    endtask

    task automatic test_branch_vs_freeze();
        clr_stats();
        set_exe_raw(1'b0, 1'b0);
        bus.mem_req      = 1'b1;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (bus.flush !== 1'b0) $display("FAIL bf_frozen_flush_c%0d: got %0b want 0", i, bus.flush); else passed++;
            total++; if (bus.hazard !== 1'b0) $display("FAIL bf_frozen_hazard_c%0d: got %0b want 0", i, bus.hazard); else passed++;
            tick();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.flush !== 1'b1) $display("FAIL bf_release_flush: got %0b want 1", bus.flush); else passed++;
        total++; if (bus.hazard !== 1'b0) $display("FAIL bf_branch_hazard: got %0b want 0", bus.hazard); else passed++;
        tick();
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b0;
        @(negedge clk);
        total++; if (bus.hazard !== 1'b1) $display("FAIL bf_plain_hazard: got %0b want 1", bus.hazard); else passed++;
        tick();
        idle();
        total++; if (bus.stall_cnt !== 4'd1) $display("FAIL bf_stall_cnt: got %0d want 1", bus.stall_cnt); else passed++;
        total++; if (bus.wait_cnt !== 4'd2) $display("FAIL bf_wait_cnt: got %0d want 2", bus.wait_cnt); else passed++;
    endtask

    task automatic test_timeout();
        logic exp_to;
        clr_stats();
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        // Cycle 0 is in RUN, cycles 1..4 are the first four WAIT cycles; the
        // flag is visible from cycle 5.
        for (int i = 0; i < 6; i++) begin
            exp_to = (i >= 5);
            @(negedge clk);
            total++; if (bus.mem_timeout !== exp_to) $display("FAIL to_flag_c%0d: got %0b want %0b", i, bus.mem_timeout, exp_to); else passed++;
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        idle();
        @(negedge clk);
        total++; if (bus.mem_timeout !== 1'b1) $display("FAIL to_sticky: got %0b want 1", bus.mem_timeout); else passed++;
        total++; if (bus.wait_cnt !== 4'd6) $display("FAIL to_wait_cnt: got %0d want 6", bus.wait_cnt); else passed++;
        tick();
        clr_stats();
        total++; if (bus.mem_timeout !== 1'b0) $display("FAIL to_cleared: got %0b want 0", bus.mem_timeout); else passed++;
        total++; if (bus.wait_cnt !== 4'd0) $display("FAIL to_wait_cleared: got %0d want 0", bus.wait_cnt); else passed++;
    endtask

    task automatic test_reset_saturation();
        clr_stats();
        set_exe_raw(1'b0, 1'b0);
        bus.mem_req      = 1'b1;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b1;
        tick();
        tick();
        total++; if (u_dut.state_q !== WAIT) $display("FAIL rs_pre_state: got %0d want %0d", u_dut.state_q, WAIT); else passed++;
        total++; if (bus.wait_cnt !== 4'd2) $display("FAIL rs_pre_wait_cnt: got %0d want 2", bus.wait_cnt); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (bus.freeze !== 1'b0) $display("FAIL rs_async_freeze: got %0b want 0", bus.freeze); else passed++;
        total++; if (bus.flush !== 1'b0) $display("FAIL rs_async_flush: got %0b want 0", bus.flush); else passed++;
        total++; if (bus.hazard !== 1'b0) $display("FAIL rs_async_hazard: got %0b want 0", bus.hazard); else passed++;
        total++; if (u_dut.state_q !== RUN) $display("FAIL rs_async_state: got %0d want %0d", u_dut.state_q, RUN); else passed++;
        total++; if (bus.wait_cnt !== 4'd0) $display("FAIL rs_async_wait_cnt: got %0d want 0", bus.wait_cnt); else passed++;
        idle();
        @(negedge clk);
        rst = 1'b1;
        tick();
        set_exe_raw(1'b0, 1'b0);
        repeat (20) tick();
        idle();
        total++; if (bus.stall_cnt !== 4'd15) $display("FAIL rs_stall_sat: got %0d want 15", bus.stall_cnt); else passed++;
        set_exe_raw(1'b0, 1'b0);
        bus.stat_clr = 1'b1;
        tick();
        idle();
        total++; if (bus.stall_cnt !== 4'd0) $display("FAIL rs_clr_priority: got %0d want 0", bus.stall_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_no_forward_raw();
        test_forward_load_use();
        test_mem_wait();
        test_branch_vs_freeze();
        test_timeout();
        test_reset_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

The pipeline sequencing controller for the forwarding core. It decides each cycle whether the decode stage must insert a bubble (`hazard` into the ID stage), whether the whole pipeline freezes while the data memory finishes a multi-cycle access, and whether the front-end stages are flushed on a taken branch. It also keeps saturating stall statistics and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- `MAX_WAIT`, default 255: the memory-wait cycle count at which `mem_timeout` sets.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `forward_en`  in  1  forwarding unit enabled.
- `id_src1`, `id_src2`  in  4  source registers of the instruction in ID.
- `id_one_src`  in  1  ID uses `id_src1`.
- `id_two_src`  in  1  ID uses `id_src2`.
- `exe_dest`  in  4  destination register of the instruction in EXE.
- `exe_wb_en`  in  1  EXE instruction writes back.
- `exe_mem_read`  in  1  EXE instruction is a load.
- `mem_dest`  in  4  destination register of the instruction in MEM.
- `mem_wb_en`  in  1  MEM instruction writes back.
- `mem_req`  in  1  MEM stage holds a load or store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `branch_taken`  in  1  EXE resolved a taken branch.
- `stat_clr`  in  1  synchronous clear of the counters and of `mem_timeout`.
- `hazard`  out  1  to ID: zero the control signals and hold PC and IF/ID.
- `freeze`  out  1  hold PC and all pipeline registers.
- `flush`  out  1  clear IF/ID and ID/EXE.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cnt`  out  `CNT_W`  number of cycles `hazard` was asserted.
- `wait_cnt`  out  `CNT_W`  number of cycles `freeze` was asserted.

## Operation
Raw hazard, computed combinationally:
- `use1 = id_one_src`, `use2 = id_two_src`.
- `hit_exe = exe_wb_en & ((use1 & id_src1==exe_dest) | (use2 & id_src2==exe_dest))`.
- `hit_mem` is the same expression using `mem_wb_en` and `mem_dest`.
- When `forward_en=0`: `raw = hit_exe | hit_mem`.
- When `forward_en=1`: `raw = hit_exe & exe_mem_read` (load-use only).

Output equations:
- `freeze = mem_req & ~mem_ready`. This holds in either FSM state, so a single-cycle access never freezes.
- `hazard = raw & ~freeze & ~branch_taken`. The instruction in ID is being flushed anyway when a branch is taken.
- `flush = branch_taken & ~freeze`. While frozen the branch stays in EXE and the flush takes effect in the release cycle.

FSM states, held in `state_t`:
- RUN:
  - `mem_req & ~mem_ready` moves to WAIT.
  - Any other combination stays in RUN.
- WAIT:
  - `mem_ready` moves to RUN.
  - `~mem_req` (abnormal drop) moves to RUN.
  - Otherwise stays in WAIT.

Wait counter:
- `wcnt` is 8 bits. It clears on entry to RUN and increments each cycle spent in WAIT.
- When `wcnt == MAX_WAIT-1` while in WAIT, `mem_timeout` sets and stays set until `stat_clr` or reset. The FSM keeps waiting.

Statistics:
- `stall_cnt` increments on each cycle with `hazard=1`. `wait_cnt` increments on each cycle with `freeze=1`.
- Both counters saturate at all-ones.
- `stat_clr` takes priority over increments in the same cycle.

## Timing
- `hazard`, `freeze` and `flush` are combinational from the current-cycle inputs, with zero latency.
- `mem_timeout`, `stall_cnt` and `wait_cnt` are registered and update one cycle after the qualifying event.
- Reset values: state RUN, `wcnt=0`, `mem_timeout=0`, `stall_cnt=0`, `wait_cnt=0`.
- While `rst=0`, the combinational outputs `hazard`, `freeze` and `flush` are forced to 0.
- Reset asserted during WAIT returns the FSM to RUN immediately (asynchronous) and clears all counters.
- Simultaneous events: freeze beats branch, and branch beats hazard.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - `state_t` (RUN, WAIT);
  - `REG_W=4`;
  - the default `CNT_W` and `MAX_WAIT` values.
- Sub-module `hazard_detect`: purely combinational `raw` generation (the compare logic and forwarding mux). It is instantiated once and can be reused by the forwarding unit.

## Test plan
1. **No-forward RAW.** `forward_en=0`, `exe_wb_en=1`, `exe_dest=3`, `id_src1=3`, `id_one_src=1` → `hazard=1` that cycle; `stall_cnt=1` on the next cycle.
2. **Forward load-use.** `forward_en=1`, same operands, `exe_mem_read=0` → `hazard=0`. Then `exe_mem_read=1` → `hazard=1`. Also check `id_src2` with `id_two_src=0` → `hazard=0`.
3. **Memory wait.** `mem_req=1`, `mem_ready=0` for 3 cycles, then `mem_ready=1` → `freeze=1` for exactly 3 cycles, FSM in WAIT for 3 cycles, `wait_cnt=3`.
4. **Branch vs freeze.** `branch_taken=1` during freeze → `flush=0` while frozen; `flush=1` in the `mem_ready` cycle. `raw=1` with `branch_taken=1` → `hazard=0`.
5. **Timeout.** `MAX_WAIT=4` with `mem_ready` held low for 6 cycles → `mem_timeout` rises after the 4th WAIT cycle and stays high after release. `stat_clr` clears it.
6. **Reset and saturation.** Assert `rst=0` mid-WAIT → outputs 0 and state RUN asynchronously. With `CNT_W=4`, 20 hazard cycles → `stall_cnt=15`.
